// File: rtl/systolic_driver_pkg.sv
// Shared types and array timing constants for the 2x2 systolic array driver.
package systolic_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN
    } state_t;

    // Array result latencies, counted from the cycle x0 is presented.
    localparam int ARR_LAT_Y0 = 2;
    localparam int ARR_LAT_Y1 = 3;
    // Extra cycles x1 trails x0 on the array operand lanes.
    localparam int X_SKEW     = 1;

    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

endpackage

// File: rtl/sd_result_fifo.sv
// Synchronous result FIFO whose head entry, valid flag and count are all registered.
module sd_result_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop_ready,
    output logic                     valid,
    output logic [WIDTH-1:0]         data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_next;
    logic [AW:0]      count_next;
    logic [WIDTH-1:0] data_next;
    logic             do_push, do_pop;

    assign do_pop  = valid && pop_ready;
    assign do_push = push && ((count != FULL_COUNT) || do_pop);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rd_ptr_next = rd_ptr;
        count_next  = count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        data_next   = '0;
        if (do_pop) begin
            rd_ptr_next = rd_ptr + 1'b1;
        end
        // The new head is the slot being written only when it becomes the sole entry.
        if (count_next != '0) begin
            if (do_push && (rd_ptr_next == wr_ptr)) begin
                data_next = push_data;
            end else begin
                data_next = mem[rd_ptr_next];
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: storage is reset too, so a reset leaves no stale results readable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            data   <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            valid  <= (count_next != '0);
            data   <= data_next;
        end
    end

endmodule

// File: rtl/systolic_driver.sv
// Feeds a 2x2 weight-stationary systolic array with skewed operands and buffers de-skewed results.
module systolic_driver
    import systolic_driver_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [DATA_WIDTH-1:0] cfg_w00,
    input  logic [DATA_WIDTH-1:0] cfg_w01,
    input  logic [DATA_WIDTH-1:0] cfg_w10,
    input  logic [DATA_WIDTH-1:0] cfg_w11,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [DATA_WIDTH-1:0] in_x0,
    input  logic [DATA_WIDTH-1:0] in_x1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [DATA_WIDTH-1:0] out_y0,
    output logic [DATA_WIDTH-1:0] out_y1,
    output logic                  arr_load_weights,
    output logic                  arr_start,
    output logic [DATA_WIDTH-1:0] arr_w00,
    output logic [DATA_WIDTH-1:0] arr_w01,
    output logic [DATA_WIDTH-1:0] arr_w10,
    output logic [DATA_WIDTH-1:0] arr_w11,
    output logic [DATA_WIDTH-1:0] arr_x0,
    output logic [DATA_WIDTH-1:0] arr_x1,
    input  logic [DATA_WIDTH-1:0] arr_y0,
    input  logic [DATA_WIDTH-1:0] arr_y1,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = 2 * DATA_WIDTH + 1;

    state_t                 state, state_next;
    tag_t                   x0_tag;
    tag_t [ARR_LAT_Y1:1]    tag_pipe;
    logic [DATA_WIDTH-1:0]  x1_dly   [X_SKEW];
    logic                   x1_dly_v [X_SKEW];
    logic [DATA_WIDTH-1:0]  y0_q;
    logic [CW-1:0]          inflight, inflight_next;
    logic [CW-1:0]          fifo_count, fifo_count_next;
    logic [CW:0]            credit_sum;
    logic                   in_ready_next, done_next;
    logic                   cfg_fire, accept, push, pop;
    logic [FW-1:0]          push_data, fifo_data;

    assign cfg_fire  = cfg_valid && cfg_ready;
    assign accept    = in_valid && in_ready;
    assign push      = tag_pipe[ARR_LAT_Y1].valid;
    assign pop       = out_valid && out_ready;
    assign push_data = {tag_pipe[ARR_LAT_Y1].last, arr_y1, y0_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        inflight_next   = inflight + CW'(accept) - CW'(push);
        fifo_count_next = fifo_count + CW'(push) - CW'(pop);
        credit_sum      = {1'b0, fifo_count_next} + {1'b0, inflight_next};
        unique case (state)
            ST_IDLE:  if (cfg_fire) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_RUN;
            ST_RUN:   if (accept && in_last) state_next = ST_DRAIN;
            ST_DRAIN: if (push && tag_pipe[ARR_LAT_Y1].last) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        // Credit covers every vector already in the array, so a push never meets a full FIFO.
        in_ready_next = (state_next == ST_RUN) && (credit_sum < (CW + 1)'(FIFO_DEPTH));
        done_next     = (state == ST_DRAIN) && (state_next == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_ready        <= 1'b1;
            in_ready         <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            arr_load_weights <= 1'b0;
            arr_start        <= 1'b0;
            arr_w00          <= '0;
            arr_w01          <= '0;
            arr_w10          <= '0;
            arr_w11          <= '0;
            arr_x0           <= '0;
            arr_x1           <= '0;
            x0_tag           <= '0;
            tag_pipe         <= '0;
            y0_q             <= '0;
            inflight         <= '0;
            for (int i = 0; i < X_SKEW; i++) begin
                x1_dly[i]   <= '0;
                x1_dly_v[i] <= 1'b0;
            end
        end else begin
            cfg_ready        <= (state_next == ST_IDLE);
            in_ready         <= in_ready_next;
            busy             <= (state_next != ST_IDLE);
            done             <= done_next;
            arr_load_weights <= (state_next == ST_LOAD);
            if (cfg_fire) begin
                arr_w00 <= cfg_w00;
                arr_w01 <= cfg_w01;
                arr_w10 <= cfg_w10;
                arr_w11 <= cfg_w11;
            end
            arr_x0       <= accept ? in_x0 : '0;
            x0_tag       <= '{valid: accept, last: accept && in_last};
            x1_dly[0]    <= accept ? in_x1 : '0;
            x1_dly_v[0]  <= accept;
            for (int i = 1; i < X_SKEW; i++) begin
                x1_dly[i]   <= x1_dly[i-1];
                x1_dly_v[i] <= x1_dly_v[i-1];
            end
            arr_x1    <= x1_dly_v[X_SKEW-1] ? x1_dly[X_SKEW-1] : '0;
            arr_start <= accept || x1_dly_v[X_SKEW-1];
            tag_pipe  <= {tag_pipe[ARR_LAT_Y1-1:1], x0_tag};
            if (tag_pipe[ARR_LAT_Y0].valid) begin
                y0_q <= arr_y0;
            end
            inflight <= inflight_next;
        end
    end

    sd_result_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop_ready (out_ready),
        .valid     (out_valid),
        .data      (fifo_data),
        .count     (fifo_count)
    );

    assign out_last = fifo_data[FW-1];
    assign out_y1   = fifo_data[2*DATA_WIDTH-1:DATA_WIDTH];
    assign out_y0   = fifo_data[DATA_WIDTH-1:0];

endmodule
